// File: rtl/control_pulses_if.sv
// Instruction-field and control-pulse bundle between the microsequencer and
// the accumulator datapath.
//   master : the sequencer (takes opcode/qc/extracode, drives every enable/select)
//   slave  : the datapath / instruction register side
interface control_pulses_if;
  logic [2:0] opcode;
  logic [1:0] qc;
  logic       extracode;
  logic       ext_flag;
  logic       mem_wr;
  logic       lp_wr;
  logic       g_wr;
  logic       q_wr;
  logic       b_wr;
  logic       a_wr;
  logic       y_wr;
  logic       x_wr;
  logic       z_wr;
  logic       maddr_mux;
  logic       mdata_mux;
  logic       lp_mux;
  logic       g_mux;
  logic       b_mux;
  logic [1:0] q_mux;
  logic [1:0] a_mux;
  logic [1:0] x_mux;
  logic [1:0] z_mux;
  logic [2:0] alu_op;
  logic [2:0] y_mux;

  modport master (
    input  opcode, qc, extracode,
    output ext_flag, mem_wr, lp_wr, g_wr, q_wr, b_wr, a_wr, y_wr, x_wr, z_wr,
           maddr_mux, mdata_mux, lp_mux, g_mux, b_mux,
           q_mux, a_mux, x_mux, z_mux, alu_op, y_mux
  );

  modport slave (
    output opcode, qc, extracode,
    input  ext_flag, mem_wr, lp_wr, g_wr, q_wr, b_wr, a_wr, y_wr, x_wr, z_wr,
           maddr_mux, mdata_mux, lp_mux, g_mux, b_mux,
           q_mux, a_mux, x_mux, z_mux, alu_op, y_mux
  );
endinterface

// File: rtl/control_pulses.sv
// control_pulses: Moore microsequencer for the accumulator CPU. Decodes the
// instruction fields in LOAD, then steps through the instruction's micro-steps
// driving register write-enables, mux selects and the ALU op code.
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset (state=LOAD, step=0, all pulses 0)
//   ctl   : control_pulses_if.master (opcode/qc/extracode in, pulses + ext_flag out)
// Build option: CONTROL_PULSES_EXTRACODE_EN enables extracode decode and a live
// ext_flag; without it extracode is ignored and ext_flag is tied to 0.
// Control outputs are registered from the next state/step, so they always equal
// the decode of the current state/step and clear asynchronously with reset.
module control_pulses (
  input  logic              clk,
  input  logic              rst_n,
  control_pulses_if.master  ctl
);

  localparam int unsigned STEP_W = 3;
  localparam int unsigned OP_W   = 3;
  localparam int unsigned QC_W   = 2;

  typedef enum logic [4:0] {
    ST_TC     = 5'd0,
    ST_TCF    = 5'd2,
    ST_ADS    = 5'd6,
    ST_MASK   = 5'd7,
    ST_CA     = 5'd8,
    ST_CS     = 5'd9,
    ST_EXTEND = 5'd11,
    ST_LOAD   = 5'd12,
    ST_TS     = 5'd13,
    ST_XCH    = 5'd14,
    ST_AD     = 5'd15,
    ST_SU     = 5'd16,
    ST_ORX    = 5'd17,
    ST_NOOP   = 5'd31
  } state_e;

  typedef struct packed {
    logic       mem_wr;
    logic       lp_wr;
    logic       g_wr;
    logic       q_wr;
    logic       b_wr;
    logic       a_wr;
    logic       y_wr;
    logic       x_wr;
    logic       z_wr;
    logic       maddr_mux;
    logic       mdata_mux;
    logic       lp_mux;
    logic       g_mux;
    logic       b_mux;
    logic [1:0] q_mux;
    logic [1:0] a_mux;
    logic [1:0] x_mux;
    logic [1:0] z_mux;
    logic [2:0] alu_op;
    logic [2:0] y_mux;
  } ctl_t;

  localparam logic [2:0] ALU_ADD  = 3'd0;
  localparam logic [2:0] ALU_AND  = 3'd1;
  localparam logic [2:0] ALU_PASS = 3'd3;
  localparam logic [2:0] ALU_NOT  = 3'd4;
  localparam logic [2:0] ALU_SUB  = 3'd5;
  localparam logic [2:0] ALU_OR   = 3'd6;

  state_e             state_q, state_d;
  logic [STEP_W-1:0]  step_q, step_d;
  logic               ext_flag_q, ext_flag_d;
  ctl_t               ctl_q, ctl_d;

  // Architectural names for the state code and step counter
  state_e             state;
  logic [STEP_W-1:0]  step;
  assign state = state_q;
  assign step  = step_q;

  state_e             dec_state;
  logic               xc_eff;
  logic [STEP_W-1:0]  last_step;
  logic [STEP_W-1:0]  tstep_d;

`ifdef CONTROL_PULSES_EXTRACODE_EN
  assign xc_eff = ctl.extracode;
`else
  logic unused_extracode;
  assign unused_extracode = ctl.extracode;
  assign xc_eff           = 1'b0;
`endif

  // Opcode/quarter-code decode performed in LOAD
  function automatic state_e decode_op(input logic [OP_W-1:0] op,
                                       input logic [QC_W-1:0] q,
                                       input logic            xc);
    state_e s;
    s = ST_NOOP;
    if (xc) begin
      case (op)
        3'd6:    s = ST_SU;
        3'd7:    s = ST_ORX;
        default: s = ST_NOOP;
      endcase
    end else begin
      case (op)
        3'd0: s = ST_TC;
        3'd1: s = ST_TCF;
        3'd2: s = ST_ADS;
        3'd3: s = ST_CA;
        3'd4: s = ST_CS;
        3'd5: begin
          case (q)
            2'd0:    s = ST_NOOP;
            2'd1:    s = ST_EXTEND;
            2'd2:    s = ST_TS;
            default: s = ST_XCH;
          endcase
        end
        3'd6:    s = ST_AD;
        default: s = ST_MASK;
      endcase
    end
    return s;
  endfunction

  // Shared memory-reference step pulses; S2 is instruction-specific and left idle
  function automatic ctl_t tmpl_ctl(input logic [STEP_W-1:0] t);
    ctl_t c;
    c = '0;
    case (t)
      3'd0: begin
        c.g_wr      = 1'b1;
        c.maddr_mux = 1'b1;
      end
      3'd1: begin
        c.x_wr = 1'b1;
        c.y_wr = 1'b1;
      end
      3'd3: begin
        c.x_wr  = 1'b1;
        c.x_mux = 2'd1;
        c.y_wr  = 1'b1;
        c.y_mux = 3'd1;
      end
      3'd4: begin
        c.z_wr   = 1'b1;
        c.z_mux  = 2'd0;
        c.alu_op = ALU_ADD;
      end
      3'd5: begin
        c.g_wr      = 1'b1;
        c.maddr_mux = 1'b0;
      end
      3'd6: c.b_wr = 1'b1;
      default: c = '0;
    endcase
    return c;
  endfunction

  // Instruction action in S2 of the memory-reference template
  function automatic ctl_t s2_action(input state_e s);
    ctl_t c;
    c = '0;
    case (s)
      ST_MASK: begin c.a_wr = 1'b1; c.alu_op = ALU_AND;  end
      ST_CA:   begin c.a_wr = 1'b1; c.alu_op = ALU_PASS; end
      ST_CS:   begin c.a_wr = 1'b1; c.alu_op = ALU_NOT;  end
      ST_AD:   begin c.a_wr = 1'b1; c.alu_op = ALU_ADD;  end
      ST_ADS:  begin c.a_wr = 1'b1; c.alu_op = ALU_ADD;  end
      ST_SU:   begin c.a_wr = 1'b1; c.alu_op = ALU_SUB;  end
      ST_ORX:  begin c.a_wr = 1'b1; c.alu_op = ALU_OR;   end
      ST_TS: begin
        c.mem_wr    = 1'b1;
        c.mdata_mux = 1'b1;
        c.maddr_mux = 1'b1;
      end
      ST_XCH: begin
        c.mem_wr    = 1'b1;
        c.mdata_mux = 1'b1;
        c.maddr_mux = 1'b1;
        c.a_wr      = 1'b1;
        c.a_mux     = 2'd1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

  // State register, step counter, extracode flag and registered pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_LOAD;
      step_q     <= '0;
      ext_flag_q <= 1'b0;
      ctl_q      <= '0;
    end else begin
      state_q    <= state_d;
      step_q     <= step_d;
      ext_flag_q <= ext_flag_d;
      ctl_q      <= ctl_d;
    end
  end

  // Next state/step, extracode flag, and pulse decode of the next state/step
  always_comb begin
    state_d    = state_q;
    step_d     = step_q + STEP_W'(1);
    ext_flag_d = ext_flag_q;
    ctl_d      = '0;
    dec_state  = decode_op(ctl.opcode, ctl.qc, xc_eff);
    last_step  = (state_q == ST_EXTEND) ? STEP_W'(3) : STEP_W'(6);

    case (state_q)
      ST_LOAD: begin
        state_d = dec_state;
        step_d  = '0;
      end
      ST_TC, ST_TCF, ST_ADS, ST_MASK, ST_CA, ST_CS, ST_EXTEND,
      ST_TS, ST_XCH, ST_AD, ST_SU, ST_ORX, ST_NOOP: begin
        if (step_q >= last_step) begin
          state_d = ST_LOAD;
          step_d  = '0;
        end
      end
      default: begin
        state_d = ST_LOAD;
        step_d  = '0;
      end
    endcase

`ifdef CONTROL_PULSES_EXTRACODE_EN
    // Set on entering EXTEND; cleared when the following ordinary instruction ends
    if (state_q == ST_LOAD) begin
      if (dec_state == ST_EXTEND) ext_flag_d = 1'b1;
    end else if (state_q != ST_EXTEND && step_q >= last_step) begin
      ext_flag_d = 1'b0;
    end
`else
    ext_flag_d = 1'b0;
`endif

    // EXTEND reuses the tail (S3-S6) of the memory-reference template
    tstep_d = (state_d == ST_EXTEND) ? (step_d + STEP_W'(3)) : step_d;

    case (state_d)
      ST_TC, ST_TCF: begin
        case (step_d)
          3'd0: ctl_d.q_wr = (state_d == ST_TC);
          3'd1: begin
            ctl_d.z_wr  = 1'b1;
            ctl_d.z_mux = 2'd1;
          end
          3'd5, 3'd6: ctl_d = tmpl_ctl(step_d);
          default: ctl_d = '0;
        endcase
      end
      ST_NOOP, ST_EXTEND: begin
        if (tstep_d >= STEP_W'(3)) ctl_d = tmpl_ctl(tstep_d);
      end
      ST_MASK, ST_CA, ST_CS, ST_AD, ST_ADS, ST_SU, ST_ORX, ST_TS, ST_XCH: begin
        ctl_d = tmpl_ctl(step_d);
        if (step_d == STEP_W'(2)) ctl_d = s2_action(state_d);
        // ADS stores the new accumulator back to M[B] alongside the S3 loads
        if (state_d == ST_ADS && step_d == STEP_W'(3)) begin
          ctl_d.mem_wr    = 1'b1;
          ctl_d.mdata_mux = 1'b1;
          ctl_d.maddr_mux = 1'b1;
        end
      end
      default: ctl_d = '0;
    endcase
  end

  assign ctl.ext_flag  = ext_flag_q;
  assign ctl.mem_wr    = ctl_q.mem_wr;
  assign ctl.lp_wr     = ctl_q.lp_wr;
  assign ctl.g_wr      = ctl_q.g_wr;
  assign ctl.q_wr      = ctl_q.q_wr;
  assign ctl.b_wr      = ctl_q.b_wr;
  assign ctl.a_wr      = ctl_q.a_wr;
  assign ctl.y_wr      = ctl_q.y_wr;
  assign ctl.x_wr      = ctl_q.x_wr;
  assign ctl.z_wr      = ctl_q.z_wr;
  assign ctl.maddr_mux = ctl_q.maddr_mux;
  assign ctl.mdata_mux = ctl_q.mdata_mux;
  assign ctl.lp_mux    = ctl_q.lp_mux;
  assign ctl.g_mux     = ctl_q.g_mux;
  assign ctl.b_mux     = ctl_q.b_mux;
  assign ctl.q_mux     = ctl_q.q_mux;
  assign ctl.a_mux     = ctl_q.a_mux;
  assign ctl.x_mux     = ctl_q.x_mux;
  assign ctl.z_mux     = ctl_q.z_mux;
  assign ctl.alu_op    = ctl_q.alu_op;
  assign ctl.y_mux     = ctl_q.y_mux;

endmodule

// File: tb/tb_control_pulses.sv
// Scoreboard bench for control_pulses: stimulus pushes the expected state and
// full pulse set for each upcoming cycle; a monitor samples on the falling edge
// and compares against the queue.
module tb_control_pulses;

`ifdef CONTROL_PULSES_EXTRACODE_EN
  localparam bit EXT_EN = 1'b1;
`else
  localparam bit EXT_EN = 1'b0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  control_pulses_if bus ();

  control_pulses dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ctl   (bus)
  );

  typedef struct packed {
    logic [4:0] state;
    logic       ext_flag;
    logic       mem_wr;
    logic       lp_wr;
    logic       g_wr;
    logic       q_wr;
    logic       b_wr;
    logic       a_wr;
    logic       y_wr;
    logic       x_wr;
    logic       z_wr;
    logic       maddr_mux;
    logic       mdata_mux;
    logic       lp_mux;
    logic       g_mux;
    logic       b_mux;
    logic [1:0] q_mux;
    logic [1:0] a_mux;
    logic [1:0] x_mux;
    logic [1:0] z_mux;
    logic [2:0] alu_op;
    logic [2:0] y_mux;
  } obs_t;

  typedef struct {
    int    idx;
    obs_t  e;
    string name;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   sidx   = 0;

  function automatic obs_t sample_dut();
    obs_t o;
    o.state     = dut.state;
    o.ext_flag  = bus.ext_flag;
    o.mem_wr    = bus.mem_wr;
    o.lp_wr     = bus.lp_wr;
    o.g_wr      = bus.g_wr;
    o.q_wr      = bus.q_wr;
    o.b_wr      = bus.b_wr;
    o.a_wr      = bus.a_wr;
    o.y_wr      = bus.y_wr;
    o.x_wr      = bus.x_wr;
    o.z_wr      = bus.z_wr;
    o.maddr_mux = bus.maddr_mux;
    o.mdata_mux = bus.mdata_mux;
    o.lp_mux    = bus.lp_mux;
    o.g_mux     = bus.g_mux;
    o.b_mux     = bus.b_mux;
    o.q_mux     = bus.q_mux;
    o.a_mux     = bus.a_mux;
    o.x_mux     = bus.x_mux;
    o.z_mux     = bus.z_mux;
    o.alu_op    = bus.alu_op;
    o.y_mux     = bus.y_mux;
    return o;
  endfunction

  // Monitor: compare every expectation due at this falling-edge sample
  always @(negedge clk) begin
    obs_t act;
    exp_t x;
    sidx = sidx + 1;
    act  = sample_dut();
    while (sb.size() > 0 && sb[0].idx <= sidx) begin
      x = sb.pop_front();
      checks = checks + 1;
      if (x.idx != sidx || act !== x.e) begin
        errors = errors + 1;
        $display("FAIL %s sample %0d: got state=%0d ef=%b bits=%h, expected state=%0d ef=%b bits=%h",
                 x.name, sidx, act.state, act.ext_flag, act[27:0],
                 x.e.state, x.e.ext_flag, x.e[27:0]);
      end
    end
  end

  function automatic obs_t load_obs(input logic ef);
    obs_t e;
    e          = '0;
    e.state    = 5'd12;
    e.ext_flag = ef;
    return e;
  endfunction

  // Expected pulses for step k of state st, written out from the step tables
  function automatic obs_t exp_step(input logic [4:0] st, input int k, input logic ef);
    obs_t e;
    int   t;
    e          = '0;
    e.state    = st;
    e.ext_flag = ef;
    t = (st == 5'd11) ? k + 3 : k;
    case (t)
      0: begin e.g_wr = 1; e.maddr_mux = 1; end
      1: begin e.x_wr = 1; e.y_wr = 1; end
      3: begin e.x_wr = 1; e.x_mux = 2'd1; e.y_wr = 1; e.y_mux = 3'd1; end
      4: begin e.z_wr = 1; end
      5: begin e.g_wr = 1; end
      6: begin e.b_wr = 1; end
      default: ;
    endcase
    if (st == 5'd0 || st == 5'd2) begin
      if (k <= 4) begin
        e          = '0;
        e.state    = st;
        e.ext_flag = ef;
      end
      if (k == 0 && st == 5'd0) e.q_wr = 1;
      if (k == 1) begin e.z_wr = 1; e.z_mux = 2'd1; end
    end else if (st == 5'd31) begin
      if (k < 3) begin
        e          = '0;
        e.state    = st;
        e.ext_flag = ef;
      end
    end else if (st != 5'd11 && k == 2) begin
      case (st)
        5'd7:  begin e.a_wr = 1; e.alu_op = 3'd1; end
        5'd8:  begin e.a_wr = 1; e.alu_op = 3'd3; end
        5'd9:  begin e.a_wr = 1; e.alu_op = 3'd4; end
        5'd15: begin e.a_wr = 1; e.alu_op = 3'd0; end
        5'd6:  begin e.a_wr = 1; e.alu_op = 3'd0; end
        5'd16: begin e.a_wr = 1; e.alu_op = 3'd5; end
        5'd17: begin e.a_wr = 1; e.alu_op = 3'd6; end
        5'd13: begin e.mem_wr = 1; e.mdata_mux = 1; e.maddr_mux = 1; end
        5'd14: begin e.mem_wr = 1; e.mdata_mux = 1; e.maddr_mux = 1;
                     e.a_wr = 1; e.a_mux = 2'd1; end
        default: ;
      endcase
    end
    if (st == 5'd6 && k == 3) begin
      e.mem_wr = 1; e.mdata_mux = 1; e.maddr_mux = 1;
    end
    return e;
  endfunction

  // Queue the expectation for the next sample, then advance one clock
  task automatic tick(input obs_t e, input string nm);
    exp_t x;
    x.idx  = sidx + 1;
    x.e    = e;
    x.name = nm;
    sb.push_back(x);
    @(negedge clk);
    #1;
  endtask

  // Issue one instruction from LOAD and check every step plus the return to LOAD
  task automatic instr(input logic [2:0] op, input logic [1:0] q, input logic xc,
                       input logic [4:0] st, input logic ef_run, input logic ef_after,
                       input string nm);
    int n;
    bus.opcode    = op;
    bus.qc        = q;
    bus.extracode = xc;
    n = (st == 5'd11) ? 4 : 7;
    for (int k = 0; k < n; k++) begin
      tick(exp_step(st, k, ef_run), $sformatf("%s_s%0d", nm, k));
      // Field changes outside LOAD must not matter
      bus.opcode    = 3'($urandom);
      bus.qc        = 2'($urandom);
      bus.extracode = 1'($urandom);
    end
    tick(load_obs(ef_after), $sformatf("%s_load", nm));
  endtask

  initial begin
    exp_t x;
    bus.opcode    = 3'd0;
    bus.qc        = 2'd0;
    bus.extracode = 1'b0;
    @(negedge clk);
    #1;
    tick(load_obs(1'b0), "in_reset");
    rst_n = 1'b1;

    instr(3'd7, 2'd0, 1'b0, 5'd7, 1'b0, 1'b0, "mask");
    instr(3'd5, 2'd1, 1'b0, 5'd11, EXT_EN, EXT_EN, "extend1");
    instr(3'd6, 2'd0, 1'b1, EXT_EN ? 5'd16 : 5'd15, EXT_EN, 1'b0, "su_or_ad");
    instr(3'd0, 2'd0, 1'b0, 5'd0, 1'b0, 1'b0, "tc");
    instr(3'd5, 2'd3, 1'b0, 5'd14, 1'b0, 1'b0, "xch");
    instr(3'd5, 2'd2, 1'b0, 5'd13, 1'b0, 1'b0, "ts");
    instr(3'd4, 2'd0, 1'b0, 5'd9, 1'b0, 1'b0, "cs");
    instr(3'd3, 2'd0, 1'b0, 5'd8, 1'b0, 1'b0, "ca");
    instr(3'd2, 2'd0, 1'b0, 5'd6, 1'b0, 1'b0, "ads");
    instr(3'd1, 2'd0, 1'b0, 5'd2, 1'b0, 1'b0, "tcf");
    instr(3'd5, 2'd0, 1'b0, 5'd31, 1'b0, 1'b0, "noop");
    instr(3'd5, 2'd1, 1'b0, 5'd11, EXT_EN, EXT_EN, "extend2");
    instr(3'd5, 2'd1, 1'b0, 5'd11, EXT_EN, EXT_EN, "extend3");
    instr(3'd3, 2'd0, 1'b1, EXT_EN ? 5'd31 : 5'd8, EXT_EN, 1'b0, "xc_op3");
    instr(3'd5, 2'd1, 1'b0, 5'd11, EXT_EN, EXT_EN, "extend4");
    instr(3'd7, 2'd0, 1'b1, EXT_EN ? 5'd17 : 5'd7, EXT_EN, 1'b0, "orx_or_mask");

    // AD interrupted by reset during S3: must be back in LOAD before any clock edge
    bus.opcode    = 3'd6;
    bus.qc        = 2'd0;
    bus.extracode = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick(exp_step(5'd15, k, 1'b0), $sformatf("ad_s%0d", k));
    end
    @(posedge clk);
    #1;
    rst_n  = 1'b0;
    x.idx  = sidx + 1;
    x.e    = load_obs(1'b0);
    x.name = "ad_async_reset";
    sb.push_back(x);
    @(negedge clk);
    #1;
    tick(load_obs(1'b0), "held_reset");
    rst_n = 1'b1;
    instr(3'd7, 2'd0, 1'b0, 5'd7, 1'b0, 1'b0, "mask_after_reset");

    repeat (2) @(negedge clk);
    #1;
    checks = checks + 1;
    if (sb.size() != 0) begin
      errors = errors + 1;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
